// File: rtl/color_select_pkg.sv
// Shared colour codes, switch-to-code mapping and LED decode for color_select.
package color_select_pkg;

  localparam int unsigned NUM_SWITCHES = 4;
  localparam int unsigned CODE_W       = 2;
  localparam int unsigned LED_W        = 4;

  localparam logic [CODE_W-1:0] COLOR_CODE_0 = 2'd0;
  localparam logic [CODE_W-1:0] COLOR_CODE_1 = 2'd1;
  localparam logic [CODE_W-1:0] COLOR_CODE_2 = 2'd2;
  localparam logic [CODE_W-1:0] COLOR_CODE_3 = 2'd3;
  localparam logic [CODE_W-1:0] COLOR_RESET  = COLOR_CODE_1;

  // Switch_1..Switch_4 select codes 1, 2, 3, 0 respectively.
  function automatic logic [CODE_W-1:0] switch_to_code(input logic [1:0] idx);
    logic [CODE_W-1:0] code;
    case (idx)
      2'd0:    code = COLOR_CODE_1;
      2'd1:    code = COLOR_CODE_2;
      2'd2:    code = COLOR_CODE_3;
      default: code = COLOR_CODE_0;
    endcase
    return code;
  endfunction

  // One-hot LED view: bit 0 = code 1, bit 1 = code 2, bit 2 = code 3, bit 3 = code 0.
  function automatic logic [LED_W-1:0] code_to_led(input logic [CODE_W-1:0] code);
    logic [LED_W-1:0] led;
    case (code)
      COLOR_CODE_1: led = 4'b0001;
      COLOR_CODE_2: led = 4'b0010;
      COLOR_CODE_3: led = 4'b0100;
      default:      led = 4'b1000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/color_select_if.sv
// Switch inputs and colour/LED outputs of the colour-select front end.
interface color_select_if;
  import color_select_pkg::*;

  logic [NUM_SWITCHES-1:0] i_switch;
  logic [CODE_W-1:0]       o_color;
  logic                    o_changed;
  logic [LED_W-1:0]        o_led;

  modport master (output i_switch, input  o_color, o_changed, o_led);
  modport slave  (input  i_switch, output o_color, o_changed, o_led);
endinterface

// File: rtl/color_select_debounce.sv
// Single-switch debouncer with registered press pulse on a stable 0->1 transition.
// Optional two-flop input synchronizer enabled by COLOR_SELECT_SYNC_EN.
module color_select_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_switch,
  output logic o_press
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sample;

`ifdef COLOR_SELECT_SYNC_EN
  logic [1:0] sync_d, sync_q;

  assign sync_d = {sync_q[0], i_switch};

  // Two-flop synchronizer for the asynchronous switch level.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) sync_q <= 2'b00;
    else         sync_q <= sync_d;
  end

  assign sample = sync_q[1];
`else
  assign sample = i_switch;
`endif

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             stable_d, stable_q;
  logic             press_d, press_q;

  // Count consecutive disagreeing cycles; accept the new level at the terminal count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sample == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_TERM) begin
      stable_d = sample;
      cnt_d    = '0;
      press_d  = sample;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/color_select.sv
// Debounced push-switch colour selector feeding the VGA sync stage's i_color.
// Define COLOR_SELECT_SYNC_EN to add a two-flop synchronizer per switch.
module color_select
  import color_select_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic           i_clock,
  input  logic           i_reset,
  color_select_if.slave  bus
);

  logic [NUM_SWITCHES-1:0] press;

  for (genvar g = 0; g < int'(NUM_SWITCHES); g++) begin : g_debounce
    color_select_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_switch (bus.i_switch[g]),
      .o_press  (press[g])
    );
  end

  logic [CODE_W-1:0] color_d, color_q;
  logic              changed_d, changed_q;
  logic [LED_W-1:0]  led_d, led_q;
  logic              sel_hit;
  logic [CODE_W-1:0] sel_code;

  // Lowest-index press wins; others in the same cycle are dropped.
  always_comb begin
    sel_hit  = 1'b0;
    sel_code = color_q;
    for (int i = int'(NUM_SWITCHES) - 1; i >= 0; i--) begin
      if (press[i]) begin
        sel_hit  = 1'b1;
        sel_code = switch_to_code(2'(i));
      end
    end
    color_d   = sel_hit ? sel_code : color_q;
    changed_d = sel_hit && (sel_code != color_q);
    led_d     = code_to_led(color_d);
  end

  // Output registers; LEDs decode the same next value as the colour.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      color_q   <= COLOR_RESET;
      changed_q <= 1'b0;
      led_q     <= code_to_led(COLOR_RESET);
    end else begin
      color_q   <= color_d;
      changed_q <= changed_d;
      led_q     <= led_d;
    end
  end

  assign bus.o_color   = color_q;
  assign bus.o_changed = changed_q;
  assign bus.o_led     = led_q;

endmodule

// File: tb/tb_color_select.sv
// Self-checking bench for color_select with DEBOUNCE_CYCLES = 4.
module tb_color_select;

  localparam int D = 4;
`ifdef COLOR_SELECT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = D + 1 + SYNC_LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  color_select_if bus();

  color_select #(.DEBOUNCE_CYCLES(D)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a switch level is accepted once the last D samples all
  // disagree with the accepted level; accepted presses land on the next edge.
  logic [1:0] m_color;
  logic       m_changed;
  logic [3:0] m_pend, m_stable, dly0, dly1;
  bit         hist [4][$];

  function automatic logic [3:0] led_of(input logic [1:0] c);
    return (c == 2'd0) ? 4'b1000 : 4'(1 << (int'(c) - 1));
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [3:0] s;
    bit found, all_diff;
    if (rst) begin
      m_color = 2'd1; m_changed = 1'b0; m_pend = '0; m_stable = '0;
      dly0 = '0; dly1 = '0;
      for (int i = 0; i < 4; i++) hist[i].delete();
    end else begin
      found = 0; m_changed = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i] && !found) begin
          found = 1;
          if (2'((i + 1) % 4) != m_color) m_changed = 1'b1;
          m_color = 2'((i + 1) % 4);
        end
      end
      if (SYNC_LAT != 0) begin
        s = dly1; dly1 = dly0; dly0 = bus.i_switch;
      end else begin
        s = bus.i_switch;
      end
      m_pend = '0;
      for (int i = 0; i < 4; i++) begin
        hist[i].push_back(s[i]);
        if (hist[i].size() > D) hist[i] = hist[i][1:$];
        all_diff = (hist[i].size() == D);
        for (int k = 0; k < hist[i].size(); k++)
          if (hist[i][k] == m_stable[i]) all_diff = 0;
        if (all_diff) begin
          m_stable[i] = s[i];
          hist[i].delete();
          if (s[i]) m_pend[i] = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_switch = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_switch = '0;
    @(negedge clk);
    n_checks++;
    if ({bus.o_color, bus.o_changed, bus.o_led} !== {2'd1, 1'b0, 4'b0001})
      $display("FAIL reset_held: got color=%0d chg=%b led=%b want 1 0 0001", bus.o_color, bus.o_changed, bus.o_led);
    else n_pass++;
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      n_checks++;
      if ({bus.o_color, bus.o_changed, bus.o_led} !== {2'd1, 1'b0, 4'b0001})
        $display("FAIL reset_idle: got color=%0d chg=%b led=%b want 1 0 0001", bus.o_color, bus.o_changed, bus.o_led);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    bus.i_switch = 4'b0010;
    for (int e = 1; e <= LAT + 3; e++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.o_color, bus.o_changed, bus.o_led} !==
          {(e >= LAT) ? 2'd2 : 2'd1, 1'(e == LAT), (e >= LAT) ? 4'b0010 : 4'b0001})
        $display("FAIL clean_press edge %0d: got color=%0d chg=%b led=%b", e, bus.o_color, bus.o_changed, bus.o_led);
      else n_pass++;
      n_checks++;
      if ({bus.o_color, bus.o_changed, bus.o_led} !== {m_color, m_changed, led_of(m_color)})
        $display("FAIL clean_press_model: got %0d %b %b want %0d %b %b", bus.o_color, bus.o_changed, bus.o_led, m_color, m_changed, led_of(m_color));
      else n_pass++;
    end
    bus.i_switch = 4'b0000;
    repeat (10) begin
      @(negedge clk);
      n_checks++;
      if ({bus.o_color, bus.o_changed, bus.o_led} !== {2'd2, 1'b0, 4'b0010})
        $display("FAIL release_no_change: got color=%0d chg=%b led=%b want 2 0 0010", bus.o_color, bus.o_changed, bus.o_led);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.i_switch = {1'b0, pat[k], 2'b00};
      @(negedge clk);
      n_checks++;
      if (bus.o_color !== m_color || m_color !== 2'd1)
        $display("FAIL bounce_reject: got color=%0d model=%0d want 1", bus.o_color, m_color);
      else n_pass++;
    end
    bus.i_switch = 4'b0100;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_color !== ((e >= LAT) ? 2'd3 : 2'd1))
        $display("FAIL bounce_hold edge %0d: got color=%0d", e, bus.o_color);
      else n_pass++;
      n_checks++;
      if ({bus.o_color, bus.o_changed, bus.o_led} !== {m_color, m_changed, led_of(m_color)})
        $display("FAIL bounce_model: got %0d %b %b want %0d %b %b", bus.o_color, bus.o_changed, bus.o_led, m_color, m_changed, led_of(m_color));
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    do_reset();
    bus.i_switch = 4'b1001;
    repeat (LAT + 4) begin
      @(negedge clk);
      n_checks++;
      if ({bus.o_color, bus.o_changed} !== {2'd1, 1'b0})
        $display("FAIL simultaneous_priority: got color=%0d chg=%b want 1 0", bus.o_color, bus.o_changed);
      else n_pass++;
    end
    bus.i_switch = 4'b0001;
    repeat (LAT + 2) @(negedge clk);
    bus.i_switch = 4'b1001;
    repeat (LAT + 3) begin
      @(negedge clk);
      pulses += int'(bus.o_changed);
      n_checks++;
      if ({bus.o_color, bus.o_changed, bus.o_led} !== {m_color, m_changed, led_of(m_color)})
        $display("FAIL override_model: got %0d %b %b want %0d %b %b", bus.o_color, bus.o_changed, bus.o_led, m_color, m_changed, led_of(m_color));
      else n_pass++;
    end
    n_checks++;
    if ({bus.o_color, bus.o_led} !== {2'd0, 4'b1000} || pulses != 1)
      $display("FAIL held_override: got color=%0d led=%b pulses=%0d want 0 1000 1", bus.o_color, bus.o_led, pulses);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.i_switch = 4'b0010;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_color, bus.o_changed, bus.o_led} !== {2'd1, 1'b0, 4'b0001})
      $display("FAIL reset_mid_async: got color=%0d chg=%b led=%b want 1 0 0001", bus.o_color, bus.o_changed, bus.o_led);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_color !== ((e >= LAT) ? 2'd2 : 2'd1))
        $display("FAIL reset_mid_repress edge %0d: got color=%0d", e, bus.o_color);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first = -1;
    bit consec = 0;
    do_reset();
    bus.i_switch = 4'b0010;
    @(negedge clk);
    bus.i_switch = 4'b0110;
    for (int e = 0; e < LAT + 4; e++) begin
      @(negedge clk);
      if (bus.o_changed === 1'b1) begin
        if (first >= 0 && e == first + 1) consec = 1;
        if (first < 0) first = e;
        pulses++;
      end
      n_checks++;
      if ({bus.o_color, bus.o_changed, bus.o_led} !== {m_color, m_changed, led_of(m_color)})
        $display("FAIL back_to_back_model: got %0d %b %b want %0d %b %b", bus.o_color, bus.o_changed, bus.o_led, m_color, m_changed, led_of(m_color));
      else n_pass++;
    end
    n_checks++;
    if (bus.o_color !== 2'd3 || pulses != 2 || !consec)
      $display("FAIL back_to_back: got color=%0d pulses=%0d consec=%0d want 3 2 1", bus.o_color, pulses, consec);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    repeat (80) begin
      bus.i_switch = 4'($urandom);
      repeat ($urandom_range(1, 8)) begin
        @(negedge clk);
        n_checks++;
        if ({bus.o_color, bus.o_changed, bus.o_led} !== {m_color, m_changed, led_of(m_color)})
          $display("FAIL random_model: got %0d %b %b want %0d %b %b", bus.o_color, bus.o_changed, bus.o_led, m_color, m_changed, led_of(m_color));
        else n_pass++;
      end
      if ($urandom_range(0, 19) == 0) begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    bus.i_switch = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
